// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter.
// Holds default widths and the requester identifiers used by lastGrant.
package regfile_wb_arbiter_pkg;

  localparam int WB_WORD_WIDTH  = 32;
  localparam int WB_REG_NUM_LOG = 5;
  localparam int WB_REG_NUM     = 1 << WB_REG_NUM_LOG;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// wb_slot: one-entry result buffer with valid/ready fill and grant drain.
// Ports: in_* fill side, drain = granted this cycle, full/addr/value held entry.
module wb_slot #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [WORD_WIDTH-1:0] in_value,
  output logic                  in_ready,
  input  logic                  drain,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_WIDTH-1:0] value
);

  logic                  full_q, full_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] value_q, value_d;
  logic                  fire;

  // A granted entry leaves at this edge, so the slot can refill at once.
  assign in_ready = !full_q || drain;
  assign fire     = in_valid && in_ready;

  always_comb begin
    full_d  = fire || (full_q && !drain);
    addr_d  = fire ? in_addr  : addr_q;
    value_d = fire ? in_value : value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      full_q  <= full_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  assign full  = full_q;
  assign addr  = addr_q;
  assign value = value_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter (ALU vs MEM, round-robin) plus per-register busy scoreboard.
// Ports: issue* scoreboard check, alu*/mem* result handshakes, write* regfile port, busyVector.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH  = WB_WORD_WIDTH,
  parameter int REG_NUM_LOG = WB_REG_NUM_LOG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issueValid,
  input  logic [REG_NUM_LOG-1:0]      issueDest,
  input  logic [REG_NUM_LOG-1:0]      issueSrc1,
  input  logic [REG_NUM_LOG-1:0]      issueSrc2,
  output logic                        issueReady,
  input  logic                        aluValid,
  input  logic [REG_NUM_LOG-1:0]      aluAddr,
  input  logic [WORD_WIDTH-1:0]       aluValue,
  output logic                        aluReady,
  input  logic                        memValid,
  input  logic [REG_NUM_LOG-1:0]      memAddr,
  input  logic [WORD_WIDTH-1:0]       memValue,
  output logic                        memReady,
  output logic                        writeEnable,
  output logic [REG_NUM_LOG-1:0]      writeAddr,
  output logic [WORD_WIDTH-1:0]       writeValue,
  output logic [(1<<REG_NUM_LOG)-1:0] busyVector
);

  localparam int REG_NUM = 1 << REG_NUM_LOG;

  logic                   alu_full, mem_full;
  logic [REG_NUM_LOG-1:0] alu_addr, mem_addr;
  logic [WORD_WIDTH-1:0]  alu_value, mem_value;

  logic                   grant_alu, grant_mem, grant_any;
  logic [REG_NUM_LOG-1:0] grant_addr;
  logic [WORD_WIDTH-1:0]  grant_value;

  req_e                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [REG_NUM_LOG-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0]  wval_q, wval_d;
  logic [REG_NUM-1:0]     busy_q, busy_d;

  wb_slot #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(REG_NUM_LOG)
  ) u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .in_valid(aluValid),
    .in_addr (aluAddr),
    .in_value(aluValue),
    .in_ready(aluReady),
    .drain   (grant_alu),
    .full    (alu_full),
    .addr    (alu_addr),
    .value   (alu_value)
  );

  wb_slot #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(REG_NUM_LOG)
  ) u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .in_valid(memValid),
    .in_addr (memAddr),
    .in_value(memValue),
    .in_ready(memReady),
    .drain   (grant_mem),
    .full    (mem_full),
    .addr    (mem_addr),
    .value   (mem_value)
  );

  // Grants use slot state only, keeping valid->ready free of comb paths.
  always_comb begin
    grant_alu = alu_full && (!mem_full || last_grant_q == REQ_MEM);
    grant_mem = mem_full && (!alu_full || last_grant_q == REQ_ALU);
    grant_any = grant_alu || grant_mem;
    grant_addr  = grant_alu ? alu_addr  : mem_addr;
    grant_value = grant_alu ? alu_value : mem_value;
    last_grant_d = grant_alu ? REQ_ALU
                 : grant_mem ? REQ_MEM
                 : last_grant_q;
  end

  assign issueReady = !(busy_q[issueSrc1] || busy_q[issueSrc2]
                        || busy_q[issueDest]);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    if (grant_any) begin
      we_d    = grant_addr != '0;
      waddr_d = grant_addr;
      wval_d  = grant_value;
    end
  end

  // Clear first, then set, so a set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (grant_any && grant_addr != '0)
      busy_d[grant_addr] = 1'b0;
    if (issueValid && issueReady && issueDest != '0)
      busy_d[issueDest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_MEM;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wval_q       <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wval_q       <= wval_d;
      busy_q       <= busy_d;
    end
  end

  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeValue  = wval_q;
  assign busyVector  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Drives after posedge, checks registered and comb outputs mid-cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueValid;
  logic [4:0]  issueDest, issueSrc1, issueSrc2;
  logic        issueReady;
  logic        aluValid, memValid;
  logic [4:0]  aluAddr, memAddr;
  logic [31:0] aluValue, memValue;
  logic        aluReady, memReady;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeValue;
  logic [31:0] busyVector;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .issueValid (issueValid),
    .issueDest  (issueDest),
    .issueSrc1  (issueSrc1),
    .issueSrc2  (issueSrc2),
    .issueReady (issueReady),
    .aluValid   (aluValid),
    .aluAddr    (aluAddr),
    .aluValue   (aluValue),
    .aluReady   (aluReady),
    .memValid   (memValid),
    .memAddr    (memAddr),
    .memValue   (memValue),
    .memReady   (memReady),
    .writeEnable(writeEnable),
    .writeAddr  (writeAddr),
    .writeValue (writeValue),
    .busyVector (busyVector)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // contention expectations, one entry per cycle
  int exp_wa  [10] = '{0, 0, 1, 9, 2, 10, 3, 11, 4, 12};
  bit exp_we  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  bit exp_ar  [10] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
  bit exp_mr  [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1};

  initial begin
    int ai;
    int mi;
    bit af;
    bit mf;
    issueValid = 0; issueDest = 0; issueSrc1 = 0; issueSrc2 = 0;
    aluValid = 0; aluAddr = 0; aluValue = 0;
    memValid = 0; memAddr = 0; memValue = 0;

    // reset with a pending ALU result
    rst = 1; aluValid = 1; aluAddr = 5'd3; aluValue = 32'h55;
    tick(); tick();
    rst = 0; aluValid = 0;
    #1;
    chk("rst_we", writeEnable, 0);
    chk("rst_busy", busyVector, 0);
    chk("rst_waddr", writeAddr, 0);
    chk("rst_wval", writeValue, 0);
    chk("rst_alu_rdy", aluReady, 1);
    chk("rst_mem_rdy", memReady, 1);
    tick();
    chk("rst_nowr1", writeEnable, 0);
    tick();
    chk("rst_nowr2", writeEnable, 0);

    // single ALU write to r5
    issueValid = 1; issueDest = 5; issueSrc1 = 1; issueSrc2 = 2;
    #1 chk("iss5_rdy", issueReady, 1);
    tick();
    issueValid = 0;
    chk("busy5_set", busyVector, 32'h20);
    aluValid = 1; aluAddr = 5; aluValue = 32'hDEADBEEF;
    #1 chk("alu5_rdy", aluReady, 1);
    tick();
    aluValid = 0;
    chk("alu5_acc_we", writeEnable, 0);
    chk("alu5_acc_busy", busyVector, 32'h20);
    tick();
    chk("alu5_we", writeEnable, 1);
    chk("alu5_wa", writeAddr, 5);
    chk("alu5_wv", writeValue, 32'hDEADBEEF);
    chk("alu5_busy_clr", busyVector, 0);
    tick();
    chk("alu5_idle_we", writeEnable, 0);
    chk("alu5_hold_wa", writeAddr, 5);

    // RAW / WAW stall on r7
    issueValid = 1; issueDest = 7; issueSrc1 = 0; issueSrc2 = 0;
    #1 chk("iss7_rdy", issueReady, 1);
    tick();
    issueValid = 0;
    issueSrc1 = 7; issueDest = 8;
    #1 chk("raw_stall", issueReady, 0);
    issueSrc1 = 0; issueDest = 7;
    #1 chk("waw_stall", issueReady, 0);
    memValid = 1; memAddr = 7; memValue = 32'h77;
    tick();
    memValid = 0;
    issueSrc1 = 7; issueDest = 8;
    #1 chk("raw_stall_acc", issueReady, 0);
    tick();
    chk("raw_release", issueReady, 1);
    chk("mem7_we", writeEnable, 1);
    chk("mem7_wa", writeAddr, 7);
    chk("mem7_wv", writeValue, 32'h77);
    issueSrc1 = 0; issueDest = 0;
    tick();

    // contention: ALU 1..4 vs MEM 9..12
    ai = 0; mi = 0;
    for (int c = 0; c < 10; c++) begin
      aluValid = ai < 4;
      aluAddr  = 5'(ai + 1);
      aluValue = 32'(32'h100 + ai + 1);
      memValid = mi < 4;
      memAddr  = 5'(mi + 9);
      memValue = 32'(32'h200 + mi + 9);
      #1;
      chk($sformatf("ct_ardy%0d", c), aluReady, exp_ar[c]);
      chk($sformatf("ct_mrdy%0d", c), memReady, exp_mr[c]);
      chk($sformatf("ct_we%0d", c), writeEnable, exp_we[c]);
      if (exp_we[c]) begin
        chk($sformatf("ct_wa%0d", c), writeAddr, exp_wa[c]);
        chk($sformatf("ct_wv%0d", c), writeValue,
            exp_wa[c] < 8 ? 32'h100 + exp_wa[c] : 32'h200 + exp_wa[c]);
      end
      af = aluValid && aluReady;
      mf = memValid && memReady;
      tick();
      if (af) ai++;
      if (mf) mi++;
    end
    aluValid = 0; memValid = 0;
    chk("ct_done_we", writeEnable, 0);

    // register 0 via MEM, with r6 busy
    issueValid = 1; issueDest = 6;
    tick();
    issueValid = 0; issueDest = 0;
    memValid = 1; memAddr = 0; memValue = 32'h1;
    #1 chk("r0_mem_rdy", memReady, 1);
    tick();
    memValid = 0;
    chk("r0_acc_we", writeEnable, 0);
    tick();
    chk("r0_we", writeEnable, 0);
    chk("r0_wa", writeAddr, 0);
    chk("r0_wv", writeValue, 1);
    chk("r0_busy", busyVector, 32'h40);
    issueValid = 1; issueDest = 0;
    #1 chk("r0_iss_rdy", issueReady, 1);
    tick();
    issueValid = 0;
    chk("r0_iss_busy", busyVector, 32'h40);
    aluValid = 1; aluAddr = 6; aluValue = 32'h6;
    tick();
    aluValid = 0;
    tick();
    chk("r6_we", writeEnable, 1);
    chk("r6_busy_clr", busyVector, 0);

    // back-to-back MEM 2,3,4
    memValid = 1; memAddr = 2; memValue = 32'h302;
    #1 chk("b2b_rdy0", memReady, 1);
    tick();
    memAddr = 3; memValue = 32'h303;
    #1 chk("b2b_rdy1", memReady, 1);
    chk("b2b_we0", writeEnable, 0);
    tick();
    memAddr = 4; memValue = 32'h304;
    #1 chk("b2b_rdy2", memReady, 1);
    chk("b2b_wa2", writeAddr, 2);
    chk("b2b_we2", writeEnable, 1);
    tick();
    memValid = 0;
    chk("b2b_wa3", writeAddr, 3);
    chk("b2b_we3", writeEnable, 1);
    tick();
    chk("b2b_wa4", writeAddr, 4);
    chk("b2b_wv4", writeValue, 32'h304);
    chk("b2b_we4", writeEnable, 1);
    tick();
    chk("b2b_idle", writeEnable, 0);

    // reset mid-operation discards slot and busy bits
    issueValid = 1; issueDest = 9;
    aluValid = 1; aluAddr = 9; aluValue = 32'hAA;
    tick();
    issueValid = 0; aluValid = 0; issueDest = 0;
    chk("mr_busy9", busyVector, 32'h200);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_we", writeEnable, 0);
    chk("mr_busy", busyVector, 0);
    chk("mr_wa", writeAddr, 0);
    tick();
    chk("mr_nowr", writeEnable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the CPU register file. It sits between the two result producers (ALU and memory unit) and the register file's single write port, and decides which result is written each cycle. It also keeps a per-register busy bit so the issue stage can stall on RAW and WAW hazards.

## Interface
Parameters:
- WORD_WIDTH, default `WORD_WIDTH (32): data width.
- REG_NUM_LOG, default `REG_NUM_LOG (5): register address width; REG_NUM = 1 << REG_NUM_LOG.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- issueValid  in  1  issue stage presents an instruction
- issueDest  in  REG_NUM_LOG  destination register of the issuing instruction
- issueSrc1, issueSrc2  in  REG_NUM_LOG  source registers
- issueReady  out  1  combinational; issue may proceed
- aluValid  in  1  ALU result available
- aluAddr  in  REG_NUM_LOG  ALU destination
- aluValue  in  WORD_WIDTH  ALU result
- aluReady  out  1  ALU handshake accept
- memValid, memAddr, memValue, memReady: same as the ALU group, for the memory unit
- writeEnable  out  1  to the register file write port, registered
- writeAddr  out  REG_NUM_LOG  registered
- writeValue  out  WORD_WIDTH  registered
- busyVector  out  REG_NUM  registered busy bits; bit 0 is always 0

## Operation
- **Slots:** each requester owns a one-entry slot (full flag, addr, value). A transfer happens when valid && ready. xReady = !full || granted_x, where granted_x depends on state only, so there is no combinational path from valid to ready.
- **Arbitration:** each cycle, choose among full slots.
  - One full slot: it wins.
  - Both full: round-robin; the winner is the requester not recorded in lastGrant.
  - lastGrant updates only on a grant.
- **Grant at posedge:** the winning slot empties, unless it is refilled at the same edge.
  - writeAddr and writeValue load from the slot.
  - writeEnable = (addr != 0).
  - busy[addr] clears.
- **No grant:** writeEnable = 0; writeAddr and writeValue hold.
- **Register 0:** an entry with address 0 still completes its handshake and consumes a grant slot, but never writes and never touches the busy bits.
- **Scoreboard:** issueReady = !busy[issueSrc1] && !busy[issueSrc2] && !busy[issueDest]. On issueValid && issueReady && issueDest != 0, busy[issueDest] sets. A WAW stall is therefore mandatory, so at most one write to each register is ever in flight.
- **Set and clear on the same register at one edge:** the set wins. This cannot occur under the rules above, but the RTL must still implement it.
- **Commit to a register whose busy bit is 0:** legal; the clear is a no-op.
- **Reset:**
  - All slots empty; busyVector = 0.
  - writeEnable = 0, writeAddr = 0, writeValue = 0.
  - lastGrant = MEM, so the ALU wins the first contended cycle.
  - Reset asserted mid-operation discards all buffered results and busy state at that edge.

## Timing
- **Accept:** a result is accepted at posedge N.
  - Earliest grant is posedge N+1; write outputs are valid during cycle N+1.
  - The register file commits at the negedge of cycle N+1.
  - The value is readable by any reader sampling at posedge N+2. The busy bit also clears at N+1, so issueReady is consistent with the data.
- **Throughput:** one write per cycle total. A single uncontended requester sustains one result per cycle through the grant-and-refill path.
- **Contention:** under continuous contention each requester gets every other cycle.
- **Issue:** a successful issue at posedge N makes busy visible from cycle N+1. A dependent instruction presented in cycle N+1 stalls.

## Structure
- Shared constants go in define.v: `REQ_ALU = 1'b0 and `REQ_MEM = 1'b1, used for lastGrant. Reuse the existing `WORD_WIDTH, `REG_NUM_LOG and `REG_NUM.
- Sub-module wb_slot: a one-entry buffer with valid/ready, fill, drain and flush. It is instantiated twice.
- Arbitration, the output register and the scoreboard live in the top module.

## Test plan
- **Reset:** assert rst for 2 cycles with aluValid = 1 -> writeEnable = 0, busyVector = 0, aluReady = 1 after release, and the pre-reset slot contents are never written.
- **Single ALU write:** issue dest = 5 at N -> busyVector[5] = 1 at N+1. aluValid with addr 5, value 0xDEADBEEF at N+2 -> writeEnable = 1, writeAddr = 5, writeValue = 0xDEADBEEF during N+3. busy[5] = 0 from N+3.
- **Contention:** ALU and MEM both valid for 4 consecutive cycles with addrs 1–4 and 9–12 -> writes alternate ALU, MEM, ALU, MEM starting with ALU. There is one write per cycle and each ready deasserts while its slot waits.
- **Hazard stall:** busy[7] = 1; issue with src1 = 7 -> issueReady = 0 until the cycle after the write to 7 is granted. Issue with dest = 7 also stalls.
- **Register 0:** MEM sends addr 0, value 0x1 -> handshake completes and a grant is consumed, but writeEnable = 0 and busyVector is unchanged. Issue with dest = 0 -> issueReady = 1 and busy[0] stays 0.
- **Back-to-back single requester:** MEM valid for 3 cycles with addrs 2, 3, 4 and ALU idle -> memReady stays 1 and the writes go to 2, 3, 4 on consecutive cycles.
